// File: rtl/stripe_arb_pkg.sv
// Shared types and constants for the stripe_arbiter round-robin scheduler.
// STRIPE_ARB_IDLE_EN (see stripe_arbiter.sv) selects the idle-symbol fill on data_out.
package stripe_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam logic [7:0] IDLE_SYMBOL = 8'hBC;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stripe_arbiter_rr_pick.sv
// Combinational round-robin finder: first asserted request at or above i_ptr, with wrap.
// NUM_REQ is a power of two, so the wrap is a plain truncating add.
module rr_pick
  import stripe_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [IDW-1:0]     o_sel,
  output logic               o_any
);

  logic [IDW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest request to i_ptr wins.
  always_comb begin
    o_sel = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = i_ptr + IDW'(i);
      if (i_req[w_idx]) begin
        o_sel = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stripe_arbiter.sv
// Round-robin burst scheduler feeding byte_striping from NUM_REQ show-ahead FIFOs.
// Define STRIPE_ARB_IDLE_EN to drive IDLE_SYMBOL on data_out during non-pop cycles.
module stripe_arbiter
  import stripe_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int IDW        = idx_w(NUM_REQ),
  localparam int CW         = idx_w(BURST_LEN)
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
  input  logic                          pause,
  output logic [NUM_REQ-1:0]            fifo_pop,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  arb_state_e            r_state;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_grant_id;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;

  logic [NUM_REQ-1:0]    w_req;
  logic [IDW-1:0]        w_sel;
  logic                  w_any;
  logic                  w_head_empty;
  logic                  w_pop_en;
  logic                  w_last;
  logic [IDW-1:0]        w_next_ptr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_fill;

  assign w_req = ~fifo_empty;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  assign w_head_empty = fifo_empty[r_grant_id];
  assign w_pop_en     = (r_state == BURST) && !w_head_empty && !pause;
  assign w_last       = (r_cnt == CW'(BURST_LEN - 1));
  assign w_next_ptr   = r_grant_id + 1'b1;
  assign w_head       = fifo_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];

`ifdef STRIPE_ARB_IDLE_EN
  assign w_fill = DATA_WIDTH'(IDLE_SYMBOL);
`else
  assign w_fill = r_data_out;
`endif

  // Pop is combinational and gated by state, so an async reset kills it at once.
  always_comb begin
    fifo_pop             = '0;
    fifo_pop[r_grant_id] = w_pop_en;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_en;
      r_data_out  <= w_pop_en ? w_head : w_fill;
      case (r_state)
        IDLE: begin
          if (!pause && w_any) begin
            r_grant_id <= w_sel;
            r_cnt      <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          // Running dry ends the grant even while paused.
          if (w_head_empty) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end else if (w_pop_en) begin
            if (w_last) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state == BURST);

  a_pop_onehot0 : assert property (@(posedge clk_2f) disable iff (reset)
    $onehot0(fifo_pop));
  a_no_pop_in_pause : assert property (@(posedge clk_2f) disable iff (reset)
    pause |-> (fifo_pop == '0));

endmodule

// File: tb/tb_stripe_arbiter.sv
// Scoreboard bench for stripe_arbiter: queue-based FIFO models, transaction-level arbitration model.
module tb_stripe_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int BL      = 4;

  logic                   clk_2f = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     fifo_empty;
  logic [NUM_REQ*DW-1:0]  fifo_data;
  logic                   pause;
  logic [NUM_REQ-1:0]     fifo_pop;
  logic [DW-1:0]          data_out;
  logic                   valid_out;
  logic [1:0]             grant_id;
  logic                   busy;

  always #5 clk_2f = ~clk_2f;

  stripe_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pause      (pause),
    .fifo_pop   (fifo_pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] g;
  } exp_t;

  logic [7:0] fq [NUM_REQ][$];
  logic [7:0] mq [NUM_REQ][$];
  exp_t       sb [$];
  exp_t       e;
  int         checks   = 0;
  int         errors   = 0;
  int         model_rr = 0;
  int         pause_pct = 0;
  int         settle   = 0;
  int         run      = 0;
  logic [7:0] last_out = 8'h00;
  logic [7:0] idle_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[i*DW +: DW] = (fq[i].size() == 0) ? 8'($urandom) : fq[i][0];
    end
  endtask

  // Reference: grant the first non-empty requester from rr, take up to BL bytes, rr = grant+1.
  task automatic plan();
    int  g;
    int  n;
    bit  done;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = fq[i];
    done = 1'b0;
    while (!done) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && mq[(model_rr + k) % NUM_REQ].size() > 0) g = (model_rr + k) % NUM_REQ;
      end
      if (g < 0) begin
        done = 1'b1;
      end else begin
        n = 0;
        while (n < BL && mq[g].size() > 0) begin
          sb.push_back('{d: mq[g].pop_front(), g: 2'(g)});
          n++;
        end
        model_rr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] pops;
    logic               pz;
    @(negedge clk_2f);
    pops = fifo_pop;
    pz   = pause;
    if (pz) chk("no_pop_in_pause", 32'(fifo_pop), 0);
    @(posedge clk_2f);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pops[i]) begin
        chk("pop_nonempty", 32'(fq[i].size() != 0), 1);
        if (fq[i].size() != 0) void'(fq[i].pop_front());
      end
    end
    drive();
    if (pz) chk("no_valid_after_pause", 32'(valid_out), 0);
    pause = ($urandom_range(99) < pause_pct);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (sb.size() > 0 && cyc < 2000) begin
      step();
      cyc++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 0);
    sb.delete();
    repeat (3) step();
    chk({name, "_idle_after"}, 32'(busy), 0);
  endtask

  // Monitor: compare each presented byte against the scoreboard head.
  always @(negedge clk_2f) begin
    if (reset) begin
      settle   = 1;
      run      = 0;
      last_out = 8'h00;
    end else if (settle > 0) begin
      settle--;
    end else if (valid_out) begin
      run++;
      chk("burst_len_cap", 32'(run <= BL), 1);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid_out), 0);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(data_out), 32'(e.d));
        chk("grant", 32'(grant_id), 32'(e.g));
        last_out = e.d;
      end
    end else begin
      run = 0;
`ifdef STRIPE_ARB_IDLE_EN
      chk("idle_symbol", 32'(data_out), 32'h0000_00BC);
`else
      chk("data_hold", 32'(data_out), 32'(last_out));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pause = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) fq[i].delete();
    drive();
    repeat (3) @(posedge clk_2f);
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    reset    = 1'b0;
    model_rr = 0;

    // Single requester: 4-byte burst, bubble, re-grant for the tail byte.
    fq[0] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'h03};
    drive();
    plan();
    step();
    chk("t1_decision_bubble", 32'(valid_out), 0);
    chk("t1_busy", 32'(busy), 1);
    step();
    chk("t1_first_valid", 32'(valid_out), 1);
    drain("t1");

    // Two requesters alternate.
    for (int k = 0; k < 8; k++) begin
      fq[1].push_back(8'($urandom));
      fq[2].push_back(8'($urandom));
    end
    drive();
    plan();
    drain("t2");

    // Pause for three cycles after two bytes.
    for (int k = 0; k < 4; k++) fq[1].push_back(8'(8'h10 + k));
    drive();
    plan();
    repeat (3) step();
    pause     = 1'b1;
    pause_pct = 100;
    repeat (2) step();
    pause_pct = 0;
    step();
    drain("t3");

    // Async reset mid-burst, with a pop pending.
    for (int k = 0; k < 8; k++) fq[2].push_back(8'(8'h20 + k));
    drive();
    plan();
    repeat (3) step();
    @(negedge clk_2f);
    #2;
    chk("t4_pop_before_rst", 32'(fifo_pop), 32'h4);
    reset = 1'b1;
    #1;
    chk("t4_pop_async_drop", 32'(fifo_pop), 0);
    chk("t4_valid_async_drop", 32'(valid_out), 0);
    chk("t4_busy_async_drop", 32'(busy), 0);
    sb.delete();
    model_rr = 0;
    repeat (2) @(posedge clk_2f);
    #1;
    chk("t4_grant_rst", 32'(grant_id), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) fq[1].push_back(8'(8'h30 + k));
    drive();
    plan();
    drain("t4");

    // Steer rr to 3, then req3 runs dry after one byte while req0 waits.
    fq[2].push_back(8'h41);
    drive();
    plan();
    drain("t5a");
    fq[3].push_back(8'h51);
    fq[0] = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive();
    plan();
    drain("t5");

    // Idle behaviour of data_out.
    repeat (4) step();
`ifdef STRIPE_ARB_IDLE_EN
    idle_exp = 8'hBC;
`else
    idle_exp = 8'h04;
`endif
    chk("t6_idle_data", 32'(data_out), 32'(idle_exp));
    chk("t6_idle_valid", 32'(valid_out), 0);

    // Randomized loads with random backpressure.
    pause_pct = 25;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int n;
        n = $urandom_range(0, 9);
        for (int k = 0; k < n; k++) fq[i].push_back(8'($urandom));
      end
      drive();
      plan();
      drain("rand");
    end
    pause_pct = 0;
    pause     = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
